// File: rtl/dot_seq_pkg.sv
// Shared definitions for the dot_seq sequencer: ALU opcodes understood by the
// external combinational ALU, and the FSM state encoding.
package dot_seq_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_PASS = 3'd2;
  localparam logic [2:0] OP_ZER  = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_MULM = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FETCH = 3'd2,
    S_MUL   = 3'd3,
    S_ACC   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/dot_seq.sv
// Dot-product sequencer: streams operand pairs and drives an external
// same-cycle combinational ALU for clear, multiply and accumulate steps.
module dot_seq
  import dot_seq_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              elem_valid,
  output logic              elem_ready,
  input  logic [DATA_W-1:0] elem_a,
  input  logic [DATA_W-1:0] elem_b,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_c,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              result_zero
);

  state_t              state;
  logic [LEN_W-1:0]    count;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   prod;
  logic [DATA_W-1:0]   a_reg;
  logic [DATA_W-1:0]   b_reg;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    alu_op = OP_PASS;
    alu_a  = '0;
    alu_b  = '0;
    case (state)
      S_CLR: alu_op = OP_ZER;
      S_MUL: begin
        alu_op = OP_MUL;
        alu_a  = a_reg;
        alu_b  = b_reg;
      end
      S_ACC: begin
        alu_op = OP_ADD;
        alu_a  = acc;
        alu_b  = prod;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register reads the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      count       <= '0;
      acc         <= '0;
      prod        <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      result      <= '0;
      result_zero <= 1'b1;
      done        <= 1'b0;
      busy        <= 1'b0;
      elem_ready  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              count <= len;
              state <= S_CLR;
            end else begin
              acc   <= '0;
              state <= S_DONE;
            end
          end
        end
        S_CLR: begin
          acc        <= alu_c;
          elem_ready <= 1'b1;
          state      <= S_FETCH;
        end
        S_FETCH: begin
          if (elem_valid) begin
            a_reg      <= elem_a;
            b_reg      <= elem_b;
            elem_ready <= 1'b0;
            state      <= S_MUL;
          end
        end
        S_MUL: begin
          prod  <= alu_c;
          state <= S_ACC;
        end
        S_ACC: begin
          acc   <= alu_c;
          count <= count - LEN_W'(1);
          if (count == LEN_W'(1)) begin
            state <= S_DONE;
          end else begin
            elem_ready <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_DONE: begin
          done        <= 1'b1;
          result      <= acc;
          result_zero <= (acc == '0);
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          busy       <= 1'b0;
          elem_ready <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dot_seq.md
DOT_SEQ -- requirements
Module: dot_seq

Interface
REQ-001 SHALL have parameter LEN_W, default 4, meaning the width of the element-count input (max 15 pairs).
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: start  in  1  begin a dot product; sampled only in IDLE.
REQ-005 SHALL have port: len  in  LEN_W  number of operand pairs; latched on accepted start.
REQ-006 SHALL have port: elem_valid  in  1  operand pair present on elem_a/elem_b.
REQ-007 SHALL have port: elem_ready  out  1  block accepts a pair this cycle.
REQ-008 SHALL have port: elem_a, elem_b  in  16 each  operand pair.
REQ-009 SHALL have port: alu_op  out  3  opcode to the downstream combinational ALU.
REQ-010 SHALL have port: alu_a, alu_b  out  16 each  ALU operand buses.
REQ-011 SHALL have port: alu_c  in  16  ALU result bus, same-cycle combinational return.
REQ-012 SHALL have port: busy  out  1  high in any state other than IDLE.
REQ-013 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-014 SHALL have port: result  out  16  last completed dot product, held until next done.
REQ-015 SHALL have port: result_zero  out  1  registered, high when result equals 0.

Function
REQ-016 SHALL implement FSM states IDLE, CLR, FETCH, MUL, ACC, DONE.
REQ-017 IDLE: start=1 with len!=0 -> latch len into count, go CLR; start=1 with len==0 -> go DONE, acc=0; otherwise stay.
REQ-018 CLR: alu_op=ZER(3), alu_a=alu_b=0; acc<=alu_c; go FETCH.
REQ-019 FETCH: elem_ready=1; on elem_valid capture elem_a/elem_b into a_reg/b_reg and go MUL; else stay, with no other state change.
REQ-020 MUL: alu_op=MUL(4), alu_a=a_reg, alu_b=b_reg; prod<=alu_c; go ACC.
REQ-021 ACC: alu_op=ADD(0), alu_a=acc, alu_b=prod; acc<=alu_c; count<=count-1; if count==1 go DONE, else go FETCH.
REQ-022 DONE: done=1 for exactly one cycle; result<=acc; result_zero<=(acc==0); go IDLE.
REQ-023 In IDLE, DONE and FETCH: alu_op SHALL be PASS(2), and alu_a and alu_b SHALL be 0.
REQ-024 elem_ready SHALL be 0 outside FETCH; elem_valid outside FETCH SHALL be ignored.
REQ-025 start while busy SHALL be ignored; len SHALL be sampled only on an accepted start.
REQ-026 All arithmetic SHALL be modulo 2^16, as returned by the ALU, with no overflow indication.
REQ-027 Latency with no stalls: done SHALL assert 3*len+2 cycles after the edge that accepted start (len=0: 1 cycle); each FETCH stall cycle adds 1.
REQ-028 alu_op/alu_a/alu_b SHALL be decoded combinationally from state and registers; all other outputs SHALL be registered.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, count=0, acc=prod=a_reg=b_reg=0, result=0, result_zero=1, done=0, busy=0.
REQ-030 Reset mid-operation SHALL abort without a done pulse and SHALL discard the partial accumulation.

Structure
REQ-031 The shared package SHALL hold the ALU opcode constants (ADD=0, SUB=1, PASS=2, ZER=3, MUL=4, MULM=5) and the FSM state encoding.
REQ-032 The block SHALL be a single module with no sub-modules; the ALU SHALL be instantiated beside it at the parent level.

Verification
REQ-033 len=3, pairs (1,2),(3,4),(5,6) with elem_valid held high -> result=44, done exactly 11 cycles after start, result_zero=0.
REQ-034 len=0 start -> done 1 cycle later, result=0, result_zero=1, elem_ready never high.
REQ-035 len=1, pair (256,256) -> product wraps to 0, result=0, result_zero=1.
REQ-036 len=2, pairs (7,3),(2,5), elem_valid low 5 cycles in the first FETCH -> alu_op=2 during the stall, result=31, done at cycle 13.
REQ-037 rst pulsed during MUL of a len=2 job -> busy=0 next cycle, no done pulse, result=0; a new start then completes normally.
REQ-038 start re-pulsed with len=7 mid-job (len=2, pairs (1,1),(1,1)) -> ignored, result=2, done at cycle 8.
